// File: rtl/dsp_share_arb.sv
// Two-client round-robin front end for a single pipelined DSP slice.
// Operands are registered onto the DSP ports; a tag pipe routes each result back to its owner.
module dsp_share_arb #(
    parameter int DSP_LAT   = 4,
    parameter     OPERATION = "ADD"
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        s0_valid,
    output logic        s0_ready,
    input  logic [17:0] s0_a,
    input  logic [17:0] s0_b,
    input  logic [17:0] s0_d,
    input  logic [47:0] s0_c,

    input  logic        s1_valid,
    output logic        s1_ready,
    input  logic [17:0] s1_a,
    input  logic [17:0] s1_b,
    input  logic [17:0] s1_d,
    input  logic [47:0] s1_c,

    output logic        r0_valid,
    input  logic        r0_ready,
    output logic [47:0] r0_p,

    output logic        r1_valid,
    input  logic        r1_ready,
    output logic [47:0] r1_p,

    output logic [17:0] dsp_a,
    output logic [17:0] dsp_b,
    output logic [17:0] dsp_d,
    output logic [47:0] dsp_c,
    input  logic [47:0] dsp_p,

    output logic        busy
);

    // Handshake rule for every port pair here: a transfer happens on the rising
    // edge where valid && ready; ready never depends on the same port's ready.

    if (DSP_LAT < 1 || DSP_LAT > 8) begin : g_bad_cfg
        $error("dsp_share_arb: DSP_LAT=%0d out of range 1..8 (OPERATION %s)", DSP_LAT, OPERATION);
    end

    logic               own0;
    logic               own1;
    logic               rr;
    logic               elig0;
    logic               elig1;
    logic               grant0;
    logic               grant1;
    logic               issue;
    logic [DSP_LAT-1:0] tag_v;
    logic [DSP_LAT-1:0] tag_id;
    logic               cap0;
    logic               cap1;

    // One outstanding op per requester keeps each result register collision-free.
    always_comb begin
        elig0  = s0_valid && !own0;
        elig1  = s1_valid && !own1;
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!rst) begin
            if (elig0 && elig1) begin
                grant0 = rr;
                grant1 = !rr;
            end else begin
                grant0 = elig0;
                grant1 = elig1;
            end
        end
    end

    assign s0_ready = grant0;
    assign s1_ready = grant1;
    assign issue    = grant0 || grant1;
    assign cap0     = tag_v[DSP_LAT-1] && !tag_id[DSP_LAT-1];
    assign cap1     = tag_v[DSP_LAT-1] &&  tag_id[DSP_LAT-1];
    assign busy     = (|tag_v) || own0 || own1;

    // Idle cycles drive zeros so the DSP never sees stale operands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dsp_a <= 18'd0;
            dsp_b <= 18'd0;
            dsp_d <= 18'd0;
            dsp_c <= 48'd0;
            rr    <= 1'b1;
        end else if (issue) begin
            dsp_a <= grant1 ? s1_a : s0_a;
            dsp_b <= grant1 ? s1_b : s0_b;
            dsp_d <= grant1 ? s1_d : s0_d;
            dsp_c <= grant1 ? s1_c : s0_c;
            rr    <= grant1;
        end else begin
            dsp_a <= 18'd0;
            dsp_b <= 18'd0;
            dsp_d <= 18'd0;
            dsp_c <= 48'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_v  <= '0;
            tag_id <= '0;
        end else begin
            tag_v[0]  <= issue;
            tag_id[0] <= grant1;
            for (int i = 1; i < DSP_LAT; i++) begin
                tag_v[i]  <= tag_v[i-1];
                tag_id[i] <= tag_id[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            own0 <= 1'b0;
            own1 <= 1'b0;
        end else begin
            if (grant0)
                own0 <= 1'b1;
            else if (r0_valid && r0_ready)
                own0 <= 1'b0;
            if (grant1)
                own1 <= 1'b1;
            else if (r1_valid && r1_ready)
                own1 <= 1'b0;
        end
    end

    // A capture can never meet an unread result of the same owner.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r0_valid <= 1'b0;
            r0_p     <= 48'd0;
            r1_valid <= 1'b0;
            r1_p     <= 48'd0;
        end else begin
            if (cap0) begin
                r0_valid <= 1'b1;
                r0_p     <= dsp_p;
            end else if (r0_valid && r0_ready) begin
                r0_valid <= 1'b0;
            end
            if (cap1) begin
                r1_valid <= 1'b1;
                r1_p     <= dsp_p;
            end else if (r1_valid && r1_ready) begin
                r1_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dsp_share_arb.sv
// Bench for dsp_share_arb: a DSP_LAT=4 instance with a pipelined (D+A)*B+C model and a DSP_LAT=1 instance.
// Expected results are queued per owner on operand handshakes and compared on result handshakes.
module tb_dsp_share_arb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        s0_valid, s0_ready, s1_valid, s1_ready;
  logic [17:0] s0_a, s0_b, s0_d, s1_a, s1_b, s1_d;
  logic [47:0] s0_c, s1_c;
  logic        r0_valid, r0_ready, r1_valid, r1_ready;
  logic [47:0] r0_p, r1_p;
  logic [17:0] dsp_a, dsp_b, dsp_d;
  logic [47:0] dsp_c, dsp_p;
  logic        busy;

  logic        b_s0_valid, b_s0_ready, b_s1_ready;
  logic [17:0] b_s0_a, b_s0_b, b_s0_d;
  logic [47:0] b_s0_c;
  logic        b_r0_valid, b_r1_valid;
  logic [47:0] b_r0_p, b_r1_p;
  logic [17:0] b_dsp_a, b_dsp_b, b_dsp_d;
  logic [47:0] b_dsp_c, b_dsp_p;
  logic        b_busy;

  int n_checks = 0;
  int n_errors = 0;
  logic [47:0] exp0_q[$];
  logic [47:0] exp1_q[$];
  int          order_q[$];

  dsp_share_arb #(.DSP_LAT(4)) u_dut (
    .clk(clk), .rst(rst),
    .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_a(s0_a), .s0_b(s0_b), .s0_d(s0_d), .s0_c(s0_c),
    .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_a(s1_a), .s1_b(s1_b), .s1_d(s1_d), .s1_c(s1_c),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_p(r0_p),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_p(r1_p),
    .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_d(dsp_d), .dsp_c(dsp_c), .dsp_p(dsp_p),
    .busy(busy)
  );

  dsp_share_arb #(.DSP_LAT(1)) u_lat1 (
    .clk(clk), .rst(rst),
    .s0_valid(b_s0_valid), .s0_ready(b_s0_ready), .s0_a(b_s0_a), .s0_b(b_s0_b), .s0_d(b_s0_d), .s0_c(b_s0_c),
    .s1_valid(1'b0), .s1_ready(b_s1_ready), .s1_a(18'd0), .s1_b(18'd0), .s1_d(18'd0), .s1_c(48'd0),
    .r0_valid(b_r0_valid), .r0_ready(1'b1), .r0_p(b_r0_p),
    .r1_valid(b_r1_valid), .r1_ready(1'b1), .r1_p(b_r1_p),
    .dsp_a(b_dsp_a), .dsp_b(b_dsp_b), .dsp_d(b_dsp_d), .dsp_c(b_dsp_c), .dsp_p(b_dsp_p),
    .busy(b_busy)
  );

  function automatic logic [47:0] model(input logic [17:0] a, b, d, input logic [47:0] c);
    return ({30'd0, d} + {30'd0, a}) * {30'd0, b} + c;
  endfunction

  // DSP model: result valid DSP_LAT edges after the operand-register update.
  logic [47:0] p_pipe [0:2];
  always @(posedge clk) begin
    p_pipe[0] <= model(dsp_a, dsp_b, dsp_d, dsp_c);
    p_pipe[1] <= p_pipe[0];
    p_pipe[2] <= p_pipe[1];
  end
  assign dsp_p   = p_pipe[2];
  assign b_dsp_p = model(b_dsp_a, b_dsp_b, b_dsp_d, b_dsp_c);

  task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Scoreboard: push on operand handshake, pop on result handshake.
  always @(negedge clk) begin
    if (!rst) begin
      check("one_grant", {47'd0, s0_ready && s1_ready}, 48'd0);
      if (s0_valid && s0_ready) begin
        exp0_q.push_back(model(s0_a, s0_b, s0_d, s0_c));
        order_q.push_back(0);
      end
      if (s1_valid && s1_ready) begin
        exp1_q.push_back(model(s1_a, s1_b, s1_d, s1_c));
        order_q.push_back(1);
      end
      if (r0_valid && r0_ready) begin
        if (exp0_q.size() == 0) check("r0_unexpected", 48'd1, 48'd0);
        else check("r0_p", r0_p, exp0_q.pop_front());
      end
      if (r1_valid && r1_ready) begin
        if (exp1_q.size() == 0) check("r1_unexpected", 48'd1, 48'd0);
        else check("r1_p", r1_p, exp1_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    exp0_q.delete();
    exp1_q.delete();
    order_q.delete();
    rst = 1'b0;
  endtask

  task automatic send(input int k, input logic [17:0] a, b, d, input logic [47:0] c);
    bit got = 1'b0;
    if (k == 0) begin
      s0_a = a; s0_b = b; s0_d = d; s0_c = c; s0_valid = 1'b1;
    end else begin
      s1_a = a; s1_b = b; s1_d = d; s1_c = c; s1_valid = 1'b1;
    end
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if ((k == 0) ? s0_ready : s1_ready) begin
        got = 1'b1;
        break;
      end
    end
    check("send_granted", {47'd0, got}, 48'd1);
    if (got) tick();
    if (k == 0) s0_valid = 1'b0;
    else        s1_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 200; n++) begin
      tick();
      if (!busy) break;
    end
    check("idle", {47'd0, busy}, 48'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [47:0] held;
    int          lat;
    bit          seen;
    s0_valid = 0; s0_a = 0; s0_b = 0; s0_d = 0; s0_c = 0;
    s1_valid = 0; s1_a = 0; s1_b = 0; s1_d = 0; s1_c = 0;
    r0_ready = 0; r1_ready = 1;
    b_s0_valid = 0; b_s0_a = 0; b_s0_b = 0; b_s0_d = 0; b_s0_c = 0;

    // Reset state
    repeat (3) tick();
    s0_valid = 1'b1;
    #1;
    check("rst_s0_ready", {47'd0, s0_ready}, 48'd0);
    s0_valid = 1'b0;
    rst = 1'b0;
    tick();
    check("rst_dsp_a", {30'd0, dsp_a}, 48'd0);
    check("rst_dsp_c", dsp_c, 48'd0);
    check("rst_r0_valid", {47'd0, r0_valid}, 48'd0);
    check("rst_r0_p", r0_p, 48'd0);
    check("rst_busy", {47'd0, busy}, 48'd0);

    // Single op with exact latency
    send(0, 18'd15, 18'd17, 18'd19, 48'd38);
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (r0_valid) begin
        lat = n;
        break;
      end
    end
    check("single_latency", 48'(lat), 48'd4);
    check("single_r0_p", r0_p, 48'd616);
    check("single_r1_idle", {47'd0, r1_valid}, 48'd0);
    check("single_busy", {47'd0, busy}, 48'd1);
    r0_ready = 1'b1;
    tick();
    check("single_busy_after_read", {47'd0, busy}, 48'd0);
    check("single_r0_dropped", {47'd0, r0_valid}, 48'd0);

    // Tie on the first cycle after reset: s0 wins, s1 follows
    rst = 1'b1;
    tick();
    exp0_q.delete(); exp1_q.delete(); order_q.delete();
    s0_a = 18'd3; s0_b = 18'd5; s0_d = 18'd7; s0_c = 48'd11; s0_valid = 1'b1;
    s1_a = 18'd2; s1_b = 18'd9; s1_d = 18'd4; s1_c = 48'd100; s1_valid = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    check("tie_s0_ready", {47'd0, s0_ready}, 48'd1);
    check("tie_s1_wait", {47'd0, s1_ready}, 48'd0);
    tick();
    s0_valid = 1'b0;
    @(negedge clk);
    check("tie_s1_ready", {47'd0, s1_ready}, 48'd1);
    tick();
    s1_valid = 1'b0;
    repeat (3) tick();
    check("tie_r0_first", {46'd0, r1_valid, r0_valid}, 48'd1);
    tick();
    check("tie_r1_next", {46'd0, r1_valid, r0_valid}, 48'd2);
    wait_idle();

    // Back-pressure on r1
    r1_ready = 1'b0;
    send(1, 18'd10, 18'd20, 18'd30, 48'd40);
    for (int n = 0; n < 20; n++) begin
      if (r1_valid) break;
      tick();
    end
    check("bp_r1_valid", {47'd0, r1_valid}, 48'd1);
    held = model(18'd10, 18'd20, 18'd30, 48'd40);
    fork
      begin
        for (int i = 0; i < 3; i++)
          send(0, 18'(i + 1), 18'd6, 18'd2, 48'(i));
      end
      send(1, 18'd1, 18'd2, 18'd3, 48'd4);
      begin
        for (int n = 0; n < 10; n++) begin
          @(negedge clk);
          check("bp_s1_ready_low", {47'd0, s1_ready}, 48'd0);
          check("bp_r1_p_held", r1_p, held);
        end
        tick();
        r1_ready = 1'b1;
        tick();
        @(negedge clk);
        check("bp_s1_reissue", {47'd0, s1_ready}, 48'd1);
      end
    join
    wait_idle();

    // Fairness: both streaming, results consumed immediately
    order_q.delete();
    fork
      for (int i = 0; i < 15; i++)
        send(0, 18'($urandom_range(0, 100)), 18'($urandom_range(0, 100)),
             18'($urandom_range(0, 100)), 48'($urandom_range(0, 100)));
      for (int i = 0; i < 15; i++)
        send(1, 18'($urandom_range(0, 100)), 18'($urandom_range(0, 100)),
             18'($urandom_range(0, 100)), 48'($urandom_range(0, 100)));
    join
    wait_idle();
    check("fair_count", 48'(order_q.size()), 48'd30);
    for (int i = 1; i < order_q.size(); i++)
      check("fair_alternate", {47'd0, order_q[i] != order_q[i-1]}, 48'd1);
    check("fair_q0_empty", 48'(exp0_q.size()), 48'd0);
    check("fair_q1_empty", 48'(exp1_q.size()), 48'd0);

    // Async reset two cycles after an issue
    send(0, 18'd50, 18'd60, 18'd70, 48'd80);
    tick();
    #3;
    rst = 1'b1;
    #1;
    check("arst_busy", {47'd0, busy}, 48'd0);
    check("arst_r0_valid", {47'd0, r0_valid}, 48'd0);
    check("arst_dsp_b", {30'd0, dsp_b}, 48'd0);
    exp0_q.delete();
    exp1_q.delete();
    tick();
    rst = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 10; n++) begin
      tick();
      if (r0_valid || r1_valid) seen = 1'b1;
    end
    check("arst_no_ghost", {47'd0, seen}, 48'd0);
    send(0, 18'd15, 18'd17, 18'd19, 48'd38);
    wait_idle();
    check("arst_q0_empty", 48'(exp0_q.size()), 48'd0);

    // DSP_LAT=1 instance
    b_s0_a = 18'd15; b_s0_b = 18'd17; b_s0_d = 18'd19; b_s0_c = 48'd38; b_s0_valid = 1'b1;
    @(negedge clk);
    check("lat1_ready", {47'd0, b_s0_ready}, 48'd1);
    tick();
    b_s0_valid = 1'b0;
    check("lat1_not_yet", {47'd0, b_r0_valid}, 48'd0);
    tick();
    check("lat1_r0_valid", {47'd0, b_r0_valid}, 48'd1);
    check("lat1_r0_p", b_r0_p, 48'd616);
    tick();
    check("lat1_idle", {47'd0, b_busy}, 48'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
